gs3x3_filter_engine: RTL and testbench
======================================

Name: gs3x3_filter_engine

Overview:
- Parametrised 3x3 Gaussian smoothing engine, the next generation of the fixed 256x256 filter top.
- Streams a raster image from a source RAM (read request plus returned valid) and writes the filtered interior pixels to a destination RAM.
- Image size and pixel width are set by parameters. An optional border-clear post-pass is available.
- Sits between two mem_wrap instances; software or the bench pulses start and waits for done.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 256, image width in pixels; must be >= 3.
- IMG_H, 256, image height in pixels; must be >= 3.
- ADDR_W, 16, RAM address width; 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start request; ignored while busy.
- src_rd_valid_o  out  1  source read request.
- src_rd_addr_o  out  ADDR_W  source read address.
- src_valid_in  in  1  returned source data valid; in order, any latency >= 1.
- src_data_in  in  DATA_W  returned source pixel.
- dst_wr_valid_o  out  1  destination write strobe; always accepted.
- dst_wr_addr_o  out  ADDR_W  destination write address.
- dst_wr_data_o  out  DATA_W  destination write data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters and line buffers' valid state cleared. This applies mid-operation too: no further reads or writes are issued after rst_n asserts.
- FSM transitions:
  - IDLE -> READ on start.
  - READ issues one read per cycle at addresses 0 .. IMG_W*IMG_H-1 with src_rd_valid_o=1, with no gaps; after the last address, READ -> DRAIN.
  - DRAIN waits until all IMG_W*IMG_H returned pixels have been consumed and the write pipeline is empty, then goes to CLEAR (macro defined) or DONE.
  - DONE asserts done for 1 cycle, deasserts busy, then -> IDLE.
- Pixel tracking: returned pixels are counted on src_valid_in to derive (r,c) in raster order. src_valid_in outside READ/DRAIN, or beyond the pixel count, is ignored.
- Line buffers: two rows of IMG_W x DATA_W, plus a 3x3 window shift register updated on each src_valid_in.
- Filter output: when pixel (r,c) arrives with r>=2 and c>=2, the block outputs the center (r-1,c-1).
  - Kernel [1 2 1; 2 4 2; 1 2 1].
  - Sum width DATA_W+4.
  - Result = (sum + 8) >> 4. This never exceeds 2^DATA_W-1, so no saturation is needed.
- Write timing: dst_wr_valid_o=1 exactly 2 cycles after the src_valid_in cycle of pixel (r,c), with dst_wr_addr_o = (r-1)*IMG_W + (c-1). Exactly (IMG_W-2)*(IMG_H-2) filtered writes occur per frame.
- Border pixels are not written by the filter pass.
- The window does not straddle rows: pixels with c<2 only fill the window and produce no write.
- The last pixel (IMG_H-1, IMG_W-1) produces the final filtered write of (IMG_H-2, IMG_W-2).
- start while busy is ignored. start in the same cycle as done is ignored; a new start is accepted only from IDLE.

Optional Feature:
- Macro: GS_BORDER_CLEAR_EN.
- Defined: after DRAIN, the CLEAR state writes 0 to every border address, one per cycle in ascending address order: row 0, then column 0 and column IMG_W-1 of rows 1..IMG_H-2, then row IMG_H-1. That is 2*IMG_W + 2*IMG_H - 4 writes, then -> DONE.
- Not defined: the CLEAR state does not exist, DRAIN -> DONE directly, and border destination locations keep their prior contents.

Test Plan:
- IMG_W=IMG_H=4, all pixels 100, 1-cycle RAM latency -> 16 reads at addresses 0..15; 4 writes at addresses 5, 6, 9, 10, all with data 100; one done pulse; busy low afterwards.
- 4x4 zeros except pixel (1,1)=255 -> writes: addr 5 = 64, addr 6 = 32, addr 9 = 32, addr 10 = 16.
- 4x4 all 255 -> all 4 writes = 255 (no overflow); 8x8 all 255 -> 36 writes = 255.
- start pulsed again during READ -> no restart; read address sequence unbroken; exactly one done.
- rst_n low mid-READ, then a new start -> outputs 0 during reset; the new frame completes with correct results and exactly 4 writes for 4x4.
- GS_BORDER_CLEAR_EN, 4x4 -> after the 4 filtered writes, 12 zero writes at 0, 1, 2, 3, 4, 7, 8, 11, 12, 13, 14, 15; then done.

Source files
------------

// File: rtl/gs3x3_filter_engine.sv
`timescale 1ns/1ps
// gs3x3_filter_engine: streams a raster image from a source RAM, applies a 3x3 Gaussian
// kernel and writes the interior pixels to a destination RAM. Define GS_BORDER_CLEAR_EN to add the border-clear pass.
module gs3x3_filter_engine #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              src_rd_valid_o,
    output logic [ADDR_W-1:0] src_rd_addr_o,
    input  logic              src_valid_in,
    input  logic [DATA_W-1:0] src_data_in,
    output logic              dst_wr_valid_o,
    output logic [ADDR_W-1:0] dst_wr_addr_o,
    output logic [DATA_W-1:0] dst_wr_data_o,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(IMG_W);
    localparam int SW = DATA_W + 4;
    localparam logic [ADDR_W:0]   NPIX      = (ADDR_W+1)'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W:0]   CTR_OFF   = (ADDR_W+1)'(IMG_W + 1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(IMG_W - 1);

`ifdef GS_BORDER_CLEAR_EN
    localparam int RW = $clog2(IMG_H);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_CLEAR, S_DONE} state_t;
    logic [RW-1:0] r_clr_row;
    logic [CW-1:0] r_clr_col;
    logic          w_clr_edge;
    assign w_clr_edge = (r_clr_row == '0) || (r_clr_row == LAST_ROW);
`else
    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
`endif

    // Valid-only streams: a read request is a single-cycle src_rd_valid_o pulse, each
    // returned pixel is one src_valid_in cycle (in order), and every dst write is taken.
    state_t              r_state;
    logic [ADDR_W:0]     r_pix_cnt;
    logic [CW-1:0]       r_col;
    logic [1:0]          r_row;
    logic                r_s1_emit;
    logic [ADDR_W-1:0]   r_s1_addr;
    logic                r_rd_valid;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_wr_valid;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_lb_a [IMG_W];
    logic [DATA_W-1:0]   r_lb_b [IMG_W];
    logic [DATA_W-1:0]   r_win [3][3];
    logic                w_px_ok;
    logic [SW-1:0]       w_sum;
    logic [DATA_W-1:0]   w_res;

    assign w_px_ok = src_valid_in && (r_state == S_READ || r_state == S_DRAIN) && (r_pix_cnt != NPIX);

    assign w_sum = SW'(r_win[0][0]) + (SW'(r_win[0][1]) << 1) + SW'(r_win[0][2])
                 + (SW'(r_win[1][0]) << 1) + (SW'(r_win[1][1]) << 2) + (SW'(r_win[1][2]) << 1)
                 + SW'(r_win[2][0]) + (SW'(r_win[2][1]) << 1) + SW'(r_win[2][2]);
    assign w_res = DATA_W'((w_sum + SW'(8)) >> 4);

    // r_lb_a holds row r-1 and r_lb_b row r-2; the window's newest column is (r-2, r-1, r).
    always_ff @(posedge clk) begin
        if (w_px_ok) begin
            r_lb_b[r_col] <= r_lb_a[r_col];
            r_lb_a[r_col] <= src_data_in;
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= r_lb_b[r_col];
            r_win[1][2] <= r_lb_a[r_col];
            r_win[2][2] <= src_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pix_cnt  <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_s1_emit  <= 1'b0;
            r_s1_addr  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef GS_BORDER_CLEAR_EN
            r_clr_row  <= '0;
            r_clr_col  <= '0;
`endif
        end else begin
            // r_row saturates at 2: only "row >= 2" matters for emitting a centre.
            r_s1_emit <= 1'b0;
            if (w_px_ok) begin
                r_pix_cnt <= r_pix_cnt + (ADDR_W+1)'(1);
                r_s1_emit <= (r_row == 2'd2) && (r_col >= CW'(2));
                r_s1_addr <= ADDR_W'(r_pix_cnt - CTR_OFF);
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    if (r_row != 2'd2) r_row <= r_row + 2'd1;
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            r_wr_valid <= r_s1_emit;
            r_wr_addr  <= r_s1_addr;
            r_wr_data  <= w_res;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_READ;
                        r_busy     <= 1'b1;
                        r_rd_valid <= 1'b1;
                        r_rd_addr  <= '0;
                        r_pix_cnt  <= '0;
                        r_col      <= '0;
                        r_row      <= '0;
                    end
                end
                S_READ: begin
                    if (r_rd_addr == LAST_ADDR) begin
                        r_rd_valid <= 1'b0;
                        r_state    <= S_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_pix_cnt == NPIX && !r_s1_emit && !r_wr_valid) begin
`ifdef GS_BORDER_CLEAR_EN
                        r_state    <= S_CLEAR;
                        r_clr_row  <= '0;
                        r_clr_col  <= '0;
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= '0;
                        r_wr_data  <= '0;
`else
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end
                end
`ifdef GS_BORDER_CLEAR_EN
                S_CLEAR: begin
                    r_wr_data <= '0;
                    if (r_clr_row == LAST_ROW && r_clr_col == LAST_COL) begin
                        r_wr_valid <= 1'b0;
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_wr_valid <= 1'b1;
                        if (!w_clr_edge && r_clr_col == '0) begin
                            r_clr_col <= LAST_COL;
                            r_wr_addr <= r_wr_addr + ADDR_W'(IMG_W - 1);
                        end else if (r_clr_col == LAST_COL) begin
                            r_clr_col <= '0;
                            r_clr_row <= r_clr_row + RW'(1);
                            r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        end else begin
                            r_clr_col <= r_clr_col + CW'(1);
                            r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign src_rd_valid_o = r_rd_valid;
    assign src_rd_addr_o  = r_rd_addr;
    assign dst_wr_valid_o = r_wr_valid;
    assign dst_wr_addr_o  = r_wr_addr;
    assign dst_wr_data_o  = r_wr_data;
    assign busy           = r_busy;
    assign done           = r_done;
endmodule

// File: tb/tb_gs3x3_filter_engine.sv
`timescale 1ns/1ps
// Bench for gs3x3_filter_engine: 4x4 and 8x8 instances, each with a source RAM model and
// a Gaussian reference computed directly from the stored image.
module tb_gs3x3_filter_engine;
    int   n_err = 0;
    int   n_chk = 0;
    int   n_fin = 0;
    logic clk   = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_cfg
        localparam int W  = (k == 0) ? 4 : 8;
        localparam int H  = W;
        localparam int N  = W * H;
        localparam int AW = 16;
`ifdef GS_BORDER_CLEAR_EN
        localparam int NB   = 2 * W + 2 * H - 4;
        localparam int BVAL = 0;
`else
        localparam int NB   = 0;
        localparam int BVAL = 170;
`endif

        logic          rst_n     = 1'b1;
        logic          start     = 1'b0;
        logic          src_valid = 1'b0;
        logic [7:0]    src_data  = 8'h00;
        logic          rd_valid;
        logic [AW-1:0] rd_addr;
        logic          wr_valid;
        logic [AW-1:0] wr_addr;
        logic [7:0]    wr_data;
        logic          busy;
        logic          done;

        gs3x3_filter_engine #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start),
            .src_rd_valid_o(rd_valid), .src_rd_addr_o(rd_addr),
            .src_valid_in(src_valid), .src_data_in(src_data),
            .dst_wr_valid_o(wr_valid), .dst_wr_addr_o(wr_addr), .dst_wr_data_o(wr_data),
            .busy(busy), .done(done)
        );

        logic [7:0]    img  [N];
        logic [7:0]    dmem [N];
        logic [55:0]   exp_q  [$];
        logic [39:0]   mem_q  [$];
        logic [AW-1:0] bord_q [$];
        int cyc = 0, pix_idx = 0, exp_rd = 0, n_rd = 0, n_wr = 0, n_done = 0;
        int max_lat = 1, last_due = 0;

        function automatic int gauss(int r, int c);
            int s = 0;
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++)
                    s += (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc))
                         * int'(img[(r + dr) * W + c + dc]);
            return (s + 8) / 16;
        endfunction

        task automatic chk(input string name, input int act, input int expv);
            n_chk++;
            if (act != expv) begin
                n_err++;
                $display("FAIL %s [%0dx%0d] got=%0d expected=%0d t=%0t", name, W, H, act, expv, $time);
            end
        endtask

        always @(posedge clk) cyc <= cyc + 1;

        always @(negedge clk) begin : p_mon
            int r, c, lat, due;
            if (!rst_n) begin
                chk("reset_outputs_zero", int'({rd_valid, wr_valid, busy, done, |rd_addr, |wr_addr, |wr_data}), 0);
                exp_q.delete();
                mem_q.delete();
                pix_idx   = 0;
                last_due  = 0;
                src_valid = 1'b0;
            end else begin
                while (exp_q.size() > 0 && int'(exp_q[0][55:24]) < cyc) begin
                    n_chk++; n_err++;
                    $display("FAIL missing_write [%0dx%0d] got=none expected_addr=%0d", W, H, int'(exp_q[0][23:8]));
                    void'(exp_q.pop_front());
                end
                if (wr_valid) begin
                    n_wr++;
                    if (int'(wr_addr) < N) dmem[wr_addr] = wr_data;
                    if (exp_q.size() > 0 && int'(exp_q[0][55:24]) == cyc) begin
                        chk("wr_addr", int'(wr_addr), int'(exp_q[0][23:8]));
                        chk("wr_data", int'(wr_data), int'(exp_q[0][7:0]));
                        void'(exp_q.pop_front());
                    end else if (exp_q.size() == 0 && bord_q.size() > 0) begin
                        chk("border_wr_addr", int'(wr_addr), int'(bord_q.pop_front()));
                        chk("border_wr_data", int'(wr_data), 0);
                    end else begin
                        n_chk++; n_err++;
                        $display("FAIL unexpected_write [%0dx%0d] got_addr=%0d expected=no write", W, H, int'(wr_addr));
                    end
                end else if (exp_q.size() > 0 && int'(exp_q[0][55:24]) == cyc) begin
                    n_chk++; n_err++;
                    $display("FAIL missing_write [%0dx%0d] got=none expected_addr=%0d", W, H, int'(exp_q[0][23:8]));
                    void'(exp_q.pop_front());
                end
                if (rd_valid) begin
                    chk("rd_addr", int'(rd_addr), exp_rd);
                    exp_rd++;
                    n_rd++;
                    lat = $urandom_range(1, max_lat);
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mem_q.push_back({32'(due), img[int'(rd_addr) % N]});
                end
                if (mem_q.size() > 0 && int'(mem_q[0][39:8]) == cyc) begin
                    src_valid = 1'b1;
                    src_data  = mem_q[0][7:0];
                    void'(mem_q.pop_front());
                    r = pix_idx / W;
                    c = pix_idx % W;
                    if (r >= 2 && c >= 2)
                        exp_q.push_back({32'(cyc + 2), 16'((r - 1) * W + c - 1), 8'(gauss(r - 1, c - 1))});
                    pix_idx++;
                end else begin
                    src_valid = 1'b0;
                    src_data  = 8'($urandom);
                end
                if (done) begin
                    n_done++;
                    chk("busy_low_at_done", int'(busy), 0);
                end
            end
        end

        // pat: 0 = all 100, 1 = single 255 at (1,1), 2 = all 255, 3 = random
        task automatic run_frame(input int pat, input int lat, input bit restart,
                                 input bit rst_mid, input int lit);
            for (int i = 0; i < N; i++) begin
                case (pat)
                    0:       img[i] = 8'd100;
                    1:       img[i] = (i == W + 1) ? 8'd255 : 8'd0;
                    2:       img[i] = 8'd255;
                    default: img[i] = 8'($urandom);
                endcase
                dmem[i] = 8'hAA;
            end
            max_lat = lat;
            exp_rd  = 0;
            n_rd    = 0;
            n_wr    = 0;
            n_done  = 0;
            pix_idx = 0;
            bord_q.delete();
`ifdef GS_BORDER_CLEAR_EN
            for (int i = 0; i < N; i++)
                if (i / W == 0 || i / W == H - 1 || i % W == 0 || i % W == W - 1)
                    bord_q.push_back(AW'(i));
`endif
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            chk("busy_after_start", int'(busy), 1);
            if (rst_mid) begin
                repeat (4) @(negedge clk);
                @(posedge clk); #1 rst_n = 1'b0;
                repeat (3) @(negedge clk);
                @(posedge clk); #1 rst_n = 1'b1;
                repeat (2) @(negedge clk);
                chk("idle_after_reset", int'({busy, rd_valid, wr_valid, done}), 0);
                return;
            end
            if (restart) begin
                repeat (3) @(negedge clk); start = 1'b1;
                @(negedge clk); start = 1'b0;
            end
            for (int t = 0; t < N * 8 + 100 && n_done == 0; t++) @(negedge clk);
            repeat (4) @(negedge clk);
            chk("done_pulses", n_done, 1);
            chk("busy_idle", int'(busy), 0);
            chk("read_count", n_rd, N);
            chk("write_count", n_wr, (W - 2) * (H - 2) + NB);
            chk("pending_writes", exp_q.size(), 0);
            for (int i = 0; i < N; i++) begin
                if (i / W == 0 || i / W == H - 1 || i % W == 0 || i % W == W - 1)
                    chk("border_cell", int'(dmem[i]), BVAL);
                else if (lit >= 0)
                    chk("interior_literal", int'(dmem[i]), lit);
                else
                    chk("interior_model", int'(dmem[i]), gauss(i / W, i % W));
            end
            if (pat == 1) begin
                chk("model_pin_center", gauss(1, 1), 64);
                chk("spike_center", int'(dmem[W + 1]), 64);
                chk("spike_right", int'(dmem[W + 2]), 32);
                chk("spike_below", int'(dmem[2 * W + 1]), 32);
                chk("spike_diag", int'(dmem[2 * W + 2]), 16);
            end
        endtask

        initial begin
            #2 rst_n = 1'b0;
            repeat (3) @(negedge clk);
            @(posedge clk); #1 rst_n = 1'b1;
            @(negedge clk);
            chk("idle_after_por", int'({busy, rd_valid, wr_valid, done}), 0);
            run_frame(0, 1, 1'b0, 1'b0, 100);
            run_frame(1, 1, 1'b0, 1'b0, -1);
            run_frame(2, 1, 1'b0, 1'b0, 255);
            run_frame(3, 2, 1'b1, 1'b0, -1);
            run_frame(3, 1, 1'b0, 1'b1, -1);
            run_frame(3, 1, 1'b0, 1'b0, -1);
            for (int i = 0; i < 3; i++) run_frame(3, 4, 1'b0, 1'b0, -1);
            n_fin++;
        end
    end

    initial begin
        for (int t = 0; t < 60000 && n_fin < 2; t++) @(posedge clk);
        if (n_fin < 2) begin
            n_chk++;
            n_err++;
            $display("FAIL bench_timeout got=%0d finished configs expected=2", n_fin);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
